store_buffer_dmem_ctrl: RTL and testbench

//  Data-memory controller directly downstream of the memory stage (MEM).

---
 rtl/store_buffer_dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_store_buffer_dmem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_dmem_ctrl.sv
// Data-memory controller behind MEM: posted-store FIFO with youngest-match
// load forwarding and a single outstanding req/ack bus transaction.
module store_buffer_dmem_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUresultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataMem,
    output logic              StallM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [PW-1:0]     rdPtr;
    logic [PW-1:0]     wrPtr;
    logic [PW:0]       count;

    logic              isLoad;
    logic              isStore;
    logic [ADDR_W-1:0] wordAddr;
    logic              full;
    logic              empty;
    logic              hit;
    logic [DATA_W-1:0] hitData;
    logic              wrAck;
    logic              rdAck;
    logic              loadMiss;
    logic              push;
    logic              pop;

    // A simultaneous read+write request is resolved as a store.
    assign isStore  = MemWriteM;
    assign isLoad   = MemReadM & ~MemWriteM;
    assign wordAddr = ALUresultM & ~ADDR_W'(3);
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign wrAck    = (state == WR_WAIT) & bus_ack;
    assign rdAck    = (state == RD_WAIT) & bus_ack;
    assign loadMiss = isLoad & ~hit;
    assign push     = isStore & ~StallM & ~reset;
    assign pop      = wrAck;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit     = 1'b0;
        hitData = '0;
        idx     = rdPtr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PW'(i);
            if ((PW+1)'(i) < count && addrQ[idx] == wordAddr) begin
                hit     = 1'b1;
                hitData = dataQ[idx];
            end
        end
    end

    always_comb begin
        StallM = 1'b0;
        if (!reset) begin
            if (isStore)
                StallM = full & ~wrAck;
            else if (loadMiss)
                StallM = ~rdAck;
        end
    end

    always_comb begin
        ReadDataMem = '0;
        if (!reset && isLoad) begin
            if (hit)
                ReadDataMem = hitData;
            else if (rdAck)
                ReadDataMem = bus_rdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addrQ[wrPtr] <= wordAddr;
            dataQ[wrPtr] <= WriteDataM;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 1'b1;
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            case (state)
                IDLE: begin
                    if (!empty) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= addrQ[rdPtr];
                        bus_wdata <= dataQ[rdPtr];
                        state     <= WR_WAIT;
                    end else if (push) begin
                        // Empty buffer: issue the incoming store as it lands at the head.
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= wordAddr;
                        bus_wdata <= WriteDataM;
                        state     <= WR_WAIT;
                    end else if (loadMiss) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= wordAddr;
                        bus_wdata <= '0;
                        state     <= RD_WAIT;
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    illegalRdWr: assert property (@(posedge CLK) disable iff (reset)
        !(MemReadM && MemWriteM));

endmodule

// File: tb/tb_store_buffer_dmem_ctrl.sv
// Directed bench for store_buffer_dmem_ctrl: store posting, forwarding,
// drain-before-read ordering, full-buffer stalls and reset recovery.
module tb_store_buffer_dmem_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUresultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataMem;
    logic        StallM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int nChecks = 0;
    int nPass   = 0;

    logic [31:0] logWe[$];
    logic [31:0] logAddr[$];
    logic [31:0] logWdata[$];
    logic [31:0] logStall[$];
    logic [31:0] logRd[$];

    store_buffer_dmem_ctrl #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK),
        .reset(reset),
        .MemReadM(MemReadM),
        .MemWriteM(MemWriteM),
        .ALUresultM(ALUresultM),
        .WriteDataM(WriteDataM),
        .ReadDataMem(ReadDataMem),
        .StallM(StallM),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idleIn();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUresultM = '0;
        WriteDataM = '0;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        MemReadM   = 1'b0;
        MemWriteM  = 1'b1;
        ALUresultM = a;
        WriteDataM = d;
    endtask

    task automatic lw(input logic [31:0] a);
        MemWriteM  = 1'b0;
        MemReadM   = 1'b1;
        ALUresultM = a;
    endtask

    task automatic clearLog();
        logWe.delete();
        logAddr.delete();
        logWdata.delete();
        logStall.delete();
        logRd.delete();
    endtask

    // Acknowledge n bus transactions, each lat cycles after req is seen.
    task automatic serve(input int n, input int lat);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (!bus_req && t < 30) begin
                step();
                t++;
            end
            if (!bus_req) begin
                check("serveTimeout", {31'd0, bus_req}, 32'd1);
                return;
            end
            repeat (lat) step();
            bus_ack = 1'b1;
            settle();
            logWe.push_back({31'd0, bus_we});
            logAddr.push_back(bus_addr);
            logWdata.push_back(bus_wdata);
            logStall.push_back({31'd0, StallM});
            logRd.push_back(ReadDataMem);
            step();
            bus_ack = 1'b0;
            if (logWe[$] == 32'd0)
                MemReadM = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        idleIn();
        MemReadM   = 1'b1;
        ALUresultM = 32'h40;
        step();
        settle();
        check("rstStall", {31'd0, StallM}, 32'd0);
        check("rstRd", ReadDataMem, 32'd0);
        step();
        reset = 1'b0;
        idleIn();
        settle();
        check("rstReq", {31'd0, bus_req}, 32'd0);
        check("rstWe", {31'd0, bus_we}, 32'd0);
        check("rstAddr", bus_addr, 32'd0);
        check("rstWdata", bus_wdata, 32'd0);

        // T1: single store, ack three cycles after issue
        sw(32'h10, 32'hDEADBEEF);
        settle();
        check("t1Stall", {31'd0, StallM}, 32'd0);
        step();
        idleIn();
        settle();
        check("t1Req", {31'd0, bus_req}, 32'd1);
        check("t1We", {31'd0, bus_we}, 32'd1);
        check("t1Addr", bus_addr, 32'h10);
        check("t1Wdata", bus_wdata, 32'hDEADBEEF);
        step();
        step();
        bus_ack = 1'b1;
        settle();
        check("t1AckReq", {31'd0, bus_req}, 32'd1);
        check("t1AckStall", {31'd0, StallM}, 32'd0);
        step();
        bus_ack = 1'b0;
        settle();
        check("t1ReqDrop", {31'd0, bus_req}, 32'd0);
        step();
        check("t1Empty", {31'd0, bus_req}, 32'd0);

        // T2: fill the buffer, fifth store stalls until the first ack
        for (int i = 0; i < 4; i++) begin
            sw(32'h100 + 32'(4 * i), 32'(i + 1));
            settle();
            check($sformatf("t2Accept%0d", i), {31'd0, StallM}, 32'd0);
            step();
        end
        sw(32'h110, 32'd5);
        settle();
        check("t2Full", {31'd0, StallM}, 32'd1);
        step();
        settle();
        check("t2FullHold", {31'd0, StallM}, 32'd1);
        step();
        bus_ack = 1'b1;
        settle();
        check("t2AckStall", {31'd0, StallM}, 32'd0);
        check("t2HeadAddr", bus_addr, 32'h100);
        check("t2HeadData", bus_wdata, 32'd1);
        step();
        bus_ack = 1'b0;
        idleIn();
        settle();
        check("t2NoB2b", {31'd0, bus_req}, 32'd0);
        step();
        check("t2NextAddr", bus_addr, 32'h104);
        sw(32'h200, 32'd9);
        settle();
        check("t2StillFull", {31'd0, StallM}, 32'd1);
        idleIn();
        clearLog();
        serve(4, 0);
        check("t2Drain0", logAddr[0], 32'h104);
        check("t2Drain1", logAddr[1], 32'h108);
        check("t2Drain2", logAddr[2], 32'h10C);
        check("t2Drain3", logAddr[3], 32'h110);
        check("t2FifthData", logWdata[3], 32'd5);

        // T3: youngest matching store is forwarded
        sw(32'h20, 32'h11);
        step();
        sw(32'h20, 32'h22);
        step();
        lw(32'h20);
        settle();
        check("t3Fwd", ReadDataMem, 32'h22);
        check("t3Stall", {31'd0, StallM}, 32'd0);
        step();
        idleIn();
        clearLog();
        serve(2, 1);
        check("t3Order0", logWdata[0], 32'h11);
        check("t3Order1", logWdata[1], 32'h22);

        // T4: load miss waits behind two pending stores
        bus_rdata = 32'hCAFEF00D;
        sw(32'h0, 32'hA1);
        step();
        sw(32'h4, 32'hA2);
        step();
        lw(32'h40);
        settle();
        check("t4MissStall", {31'd0, StallM}, 32'd1);
        check("t4MissRd", ReadDataMem, 32'd0);
        clearLog();
        serve(3, 2);
        check("t4W0We", logWe[0], 32'd1);
        check("t4W0Addr", logAddr[0], 32'h0);
        check("t4W0Stall", logStall[0], 32'd1);
        check("t4W1Addr", logAddr[1], 32'h4);
        check("t4RdWe", logWe[2], 32'd0);
        check("t4RdAddr", logAddr[2], 32'h40);
        check("t4RdStall", logStall[2], 32'd0);
        check("t4RdData", logRd[2], 32'hCAFEF00D);
        settle();
        check("t4NoLoadRd", ReadDataMem, 32'd0);

        // T5: reset in RD_WAIT with a late ack
        lw(32'h80);
        step();
        check("t5Req", {31'd0, bus_req}, 32'd1);
        check("t5We", {31'd0, bus_we}, 32'd0);
        check("t5Addr", bus_addr, 32'h80);
        reset = 1'b1;
        settle();
        check("t5RstStall", {31'd0, StallM}, 32'd0);
        check("t5RstRd", ReadDataMem, 32'd0);
        step();
        reset   = 1'b0;
        idleIn();
        bus_ack = 1'b1;
        settle();
        check("t5ReqCleared", {31'd0, bus_req}, 32'd0);
        check("t5LateStall", {31'd0, StallM}, 32'd0);
        step();
        bus_ack = 1'b0;
        check("t5AckIgnored", {31'd0, bus_req}, 32'd0);
        sw(32'h84, 32'h55);
        step();
        idleIn();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        bus_rdata = 32'h77;
        lw(32'h84);
        settle();
        check("t5FifoCleared", {31'd0, StallM}, 32'd1);
        clearLog();
        serve(1, 0);
        check("t5RdAddr", logAddr[0], 32'h84);
        check("t5RdData", logRd[0], 32'h77);

        // T6: low address bits ignored
        sw(32'h27, 32'h6666);
        step();
        lw(32'h25);
        settle();
        check("t6Fwd", ReadDataMem, 32'h6666);
        check("t6Stall", {31'd0, StallM}, 32'd0);
        check("t6BusAddr", bus_addr, 32'h24);
        step();
        idleIn();
        clearLog();
        serve(1, 0);
        check("t6LogAddr", logAddr[0], 32'h24);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
